// File: rtl/temp_poller_pkg.sv
// temp_poller_pkg: shared FSM state type and constants for the temperature poller.
package temp_poller_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT, CONV, PUB} state_e;
  localparam logic [31:0] CTRL_START = 32'h1;
  localparam int TEMP_W   = 16;
  localparam int SAMPLE_W = 13;
  function automatic logic [TEMP_W-1:0] sext_sample(input logic [SAMPLE_W-1:0] s);
    return {{(TEMP_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction
endpackage

// File: rtl/bcd_dd8.sv
// bcd_dd8: sequential 8-bit binary to 3-digit BCD double-dabble, one bit per cycle.
// A start while busy restarts the conversion; neg_i is carried through to align with the digits.
module bcd_dd8 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic        neg_i,
  input  logic [7:0]  bin_i,
  output logic [11:0] bcd_o,
  output logic        neg_o,
  output logic        done_o
);
  logic [19:0] sr_q, sr_d, adj;
  logic [11:0] bcd_q;
  logic [2:0]  cnt_q;
  logic        busy_q, neg_q, neg_out_q, done_q;
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < 3; i++)
      adj[8+4*i +: 4] = (adj[8+4*i +: 4] >= 4'd5) ? adj[8+4*i +: 4] + 4'd3 : adj[8+4*i +: 4];
    sr_d = {adj[18:0], 1'b0};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q      <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      neg_q     <= 1'b0;
      neg_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        sr_q   <= {12'd0, bin_i};
        cnt_q  <= '0;
        busy_q <= 1'b1;
        neg_q  <= neg_i;
      end else if (busy_q) begin
        sr_q  <= sr_d;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == 3'd7) begin
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          bcd_q     <= sr_d[19:8];
          neg_out_q <= neg_q;
        end
      end
    end
  end
  assign bcd_o  = bcd_q;
  assign neg_o  = neg_out_q;
  assign done_o = done_q;
endmodule

// File: rtl/temp_poller.sv
// temp_poller: periodic poller for the I2C temperature sensor with EMA filter, hysteretic
// over-temperature alarm and done timeout; define TEMP_POLLER_BCD_EN for a BCD readout of the average.
module temp_poller
  import temp_poller_pkg::*;
#(
  parameter int PERIOD_CYCLES  = 10_000_000,
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int AVG_SHIFT      = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        poll_en,
  input  logic [15:0] th_high,
  input  logic [15:0] hyst,
  output logic        temp_ctrl_we,
  output logic [31:0] temp_ctrl_wdata,
  input  logic [31:0] temp_data_rdata,
  input  logic        temp_done_rdata,
  output logic [15:0] temp_raw,
  output logic [15:0] temp_avg,
  output logic        sample_valid,
  output logic        alarm,
  output logic        timeout_err,
  output logic [15:0] sample_cnt
`ifdef TEMP_POLLER_BCD_EN
  ,
  output logic [15:0] temp_bcd,
  output logic        bcd_valid
`endif
);
  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_e                 state_q, state_d;
  logic [PW-1:0]          pcnt_q, pcnt_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [SAMPLE_W-1:0]    code_q;
  logic [TEMP_W-1:0]      sample_q, raw_q, avg_q, avg_d, cnt_q;
  logic                   valid_q, alarm_q, alarm_d, terr_q, timeout_hit;
  logic                   poll_en_q, avg_init_q, unused_ok;
  logic signed [TEMP_W:0] diff, step, avg_sum, lo_th;
  always_comb begin
    state_d         = state_q;
    tcnt_d          = tcnt_q;
    temp_ctrl_we    = 1'b0;
    temp_ctrl_wdata = '0;
    timeout_hit     = 1'b0;
    case (state_q)
      IDLE: state_d = (poll_en && pcnt_q == '0) ? TRIG : IDLE;
      TRIG: begin
        temp_ctrl_we    = 1'b1;
        temp_ctrl_wdata = CTRL_START;
        tcnt_d          = '0;
        state_d         = WAIT;
      end
      WAIT: begin
        if (temp_done_rdata) state_d = CONV;
        else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else tcnt_d = tcnt_q + 1'b1;
      end
      CONV: state_d = PUB;
      PUB:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign pcnt_d = (!poll_en || pcnt_q == PW'(PERIOD_CYCLES - 1)) ? '0 : pcnt_q + 1'b1;
  // Kept as separate signed terms so the >>> stays arithmetic.
  assign diff    = $signed({sample_q[TEMP_W-1], sample_q}) - $signed({avg_q[TEMP_W-1], avg_q});
  assign step    = diff >>> AVG_SHIFT;
  assign avg_sum = $signed({avg_q[TEMP_W-1], avg_q}) + step;
  assign avg_d   = avg_init_q ? avg_sum[TEMP_W-1:0] : sample_q;
  assign lo_th   = $signed({th_high[TEMP_W-1], th_high}) - $signed({1'b0, hyst});
  assign alarm_d = ($signed(avg_d) >= $signed(th_high)) ? 1'b1 :
                   ($signed({avg_d[TEMP_W-1], avg_d}) < lo_th) ? 1'b0 : alarm_q;
  assign unused_ok = ^{temp_data_rdata[31:16], temp_data_rdata[2:0]};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      tcnt_q     <= '0;
      code_q     <= '0;
      sample_q   <= '0;
      raw_q      <= '0;
      avg_q      <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      alarm_q    <= 1'b0;
      terr_q     <= 1'b0;
      poll_en_q  <= 1'b0;
      avg_init_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      tcnt_q    <= tcnt_d;
      poll_en_q <= poll_en;
      valid_q   <= (state_q == PUB);
      if (state_q == WAIT && temp_done_rdata) code_q <= temp_data_rdata[15:3];
      if (state_q == CONV) sample_q <= sext_sample(code_q);
      if (timeout_hit) terr_q <= 1'b1;
      if (state_q == PUB) begin
        raw_q   <= sample_q;
        avg_q   <= avg_d;
        alarm_q <= alarm_d;
        cnt_q   <= cnt_q + 1'b1;
        terr_q  <= 1'b0;
      end
      // A fresh enable restarts the filter from the next sample.
      if (poll_en && !poll_en_q) avg_init_q <= 1'b0;
      else if (state_q == PUB) avg_init_q <= 1'b1;
    end
  end
  assign temp_raw     = raw_q;
  assign temp_avg     = avg_q;
  assign sample_valid = valid_q;
  assign alarm        = alarm_q;
  assign timeout_err  = terr_q;
  assign sample_cnt   = cnt_q;
`ifdef TEMP_POLLER_BCD_EN
  logic [TEMP_W-1:0] abs_avg;
  logic [11:0]       bcd_digits;
  logic              bcd_neg, unused_bcd;
  assign abs_avg    = avg_d[TEMP_W-1] ? -avg_d : avg_d;
  assign unused_bcd = ^{abs_avg[15:12], abs_avg[3:0]};
  bcd_dd8 u_bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (state_q == PUB),
    .neg_i   (avg_d[TEMP_W-1]),
    .bin_i   (abs_avg[11:4]),
    .bcd_o   (bcd_digits),
    .neg_o   (bcd_neg),
    .done_o  (bcd_valid)
  );
  assign temp_bcd = {bcd_neg ? 4'hF : 4'h0, bcd_digits};
`endif
endmodule

// File: tb/tb_temp_poller.sv
// tb_temp_poller: scoreboard bench; two instances (AVG_SHIFT 0 and 2) share one sensor model.
module tb_temp_poller;
  localparam int PER = 100, TMO = 50, DLY = 20;
  logic clk = 1'b0, reset_n = 1'b1, poll_en = 1'b0, done = 1'b0;
  logic [15:0] th_high = 16'h0190, hyst = 16'h0020;
  logic [31:0] rdata = '0;
  logic we0, we2, sv0, sv2, al0, al2, te0, te2;
  logic [31:0] wd0, wd2;
  logic [15:0] raw0, raw2, avg0, avg2, cnt0, cnt2;
  int n_cmp = 0, n_bad = 0, cyc = 0, last_stb = -1;
  typedef struct {
    logic [15:0] raw, a0, a2, cnt;
    logic al0, al2;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t me;
  logic [15:0] m_a0, m_a2, m_cnt, m_raw;
  logic m_al0, m_al2, m_first;
  temp_poller #(.PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(TMO), .AVG_SHIFT(0)) u0 (
    .clk(clk), .reset_n(reset_n), .poll_en(poll_en), .th_high(th_high), .hyst(hyst),
    .temp_ctrl_we(we0), .temp_ctrl_wdata(wd0), .temp_data_rdata(rdata), .temp_done_rdata(done),
    .temp_raw(raw0), .temp_avg(avg0), .sample_valid(sv0), .alarm(al0), .timeout_err(te0),
    .sample_cnt(cnt0));
  temp_poller #(.PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(TMO), .AVG_SHIFT(2)) u2 (
    .clk(clk), .reset_n(reset_n), .poll_en(poll_en), .th_high(th_high), .hyst(hyst),
    .temp_ctrl_we(we2), .temp_ctrl_wdata(wd2), .temp_data_rdata(rdata), .temp_done_rdata(done),
    .temp_raw(raw2), .temp_avg(avg2), .sample_valid(sv2), .alarm(al2), .timeout_err(te2),
    .sample_cnt(cnt2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] ema(input logic [15:0] a, input logic [15:0] s, input int sh);
    logic signed [16:0] d;
    d = $signed({s[15], s}) - $signed({a[15], a});
    d = d >>> sh;
    return a + d[15:0];
  endfunction
  function automatic logic alm(input logic [15:0] a, input logic prev);
    if ($signed(a) >= $signed(th_high)) return 1'b1;
    if (int'($signed(a)) < int'($signed(th_high)) - int'(hyst)) return 1'b0;
    return prev;
  endfunction
  task automatic model_reset();
    m_a0 = '0; m_a2 = '0; m_cnt = '0; m_raw = '0;
    m_al0 = 1'b0; m_al2 = 1'b0; m_first = 1'b1;
  endtask
  task automatic push(input logic [15:0] r);
    exp_t e;
    m_a0 = m_first ? r : ema(m_a0, r, 0);
    m_a2 = m_first ? r : ema(m_a2, r, 2);
    m_first = 1'b0;
    m_al0 = alm(m_a0, m_al0);
    m_al2 = alm(m_a2, m_al2);
    m_cnt = m_cnt + 16'd1;
    m_raw = r;
    e = '{r, m_a0, m_a2, m_cnt, m_al0, m_al2, cyc + 3};
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (reset_n && sv0) begin
      if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        me = q.pop_front();
        chk("latency", cyc, me.cyc);
        chk("raw0", raw0, me.raw);
        chk("raw2", raw2, me.raw);
        chk("avg0", avg0, me.a0);
        chk("avg2", avg2, me.a2);
        chk("alarm0", al0, me.al0);
        chk("alarm2", al2, me.al2);
        chk("cnt0", cnt0, me.cnt);
        chk("cnt2", cnt2, me.cnt);
        chk("valid2", sv2, 1);
        chk("terr0_clr", te0, 0);
        chk("terr2_clr", te2, 0);
      end
    end
  end
  task automatic wait_stb(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * PER; i++) begin
      if (we0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin chk("strobe_seen", 32'd0, 32'd1); return; end
    chk("wdata", wd0, 32'h1);
    chk("we2", we2, 1);
    if (last_stb >= 0) chk("period", cyc - last_stb, PER);
    last_stb = cyc;
    @(negedge clk);
    chk("we_width", we0, 0);
    chk("wdata_idle", wd0, 32'h0);
  endtask
  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      chk("drain", q.size(), 0);
      q.delete();
    end
  endtask
  task automatic txn(input logic [31:0] d, input logic [15:0] r);
    bit ok;
    wait_stb(ok);
    if (!ok) return;
    repeat (DLY - 1) @(negedge clk);
    rdata = d;
    done = 1'b1;
    push(r);
    @(negedge clk);
    done = 1'b0;
    rdata = $urandom;
    drain();
  endtask
  logic [31:0] tv_d [6] = '{32'h0C78, 32'h0C80, 32'h0BC0, 32'h0B78, 32'hE480, 32'hFFFF0C87};
  logic [15:0] tv_r [6] = '{16'h018F, 16'h0190, 16'h0178, 16'h016F, 16'hFC90, 16'h0190};
  logic        tv_a [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  initial begin
    bit ok;
    int n_stb;
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    chk("rst_raw", raw0, 0); chk("rst_avg", avg0, 0); chk("rst_valid", sv0, 0);
    chk("rst_alarm", al0, 0); chk("rst_terr", te0, 0); chk("rst_cnt", cnt0, 0);
    chk("rst_we", we0, 0); chk("rst_wdata", wd0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    poll_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      txn(tv_d[i], tv_r[i]);
      chk("alarm_plan", al0, tv_a[i]);
    end
    wait_stb(ok);
    if (ok) begin
      repeat (45) @(negedge clk);
      chk("terr_before", te0, 0);
      repeat (10) @(negedge clk);
      chk("terr0_set", te0, 1);
      chk("terr2_set", te2, 1);
      chk("raw_hold", raw0, m_raw);
      chk("cnt_hold", cnt0, m_cnt);
    end
    txn(32'h0A00, 16'h0140);
    poll_en = 1'b0;
    n_stb = 0;
    repeat (250) begin
      @(negedge clk);
      if (we0) n_stb++;
    end
    chk("no_strobe_disabled", n_stb, 0);
    poll_en = 1'b1;
    m_first = 1'b1;
    last_stb = -1;
    txn(32'h0800, 16'h0100);
    chk("ema_first", avg2, 16'h0100);
    txn(32'h1000, 16'h0200);
    chk("ema_second", avg2, 16'h0140);
    wait_stb(ok);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_raw", raw0, 0); chk("arst_avg", avg0, 0); chk("arst_avg2", avg2, 0);
    chk("arst_valid", sv0, 0); chk("arst_alarm", al0, 0); chk("arst_terr", te0, 0);
    chk("arst_cnt", cnt0, 0); chk("arst_we", we0, 0); chk("arst_wdata", wd0, 0);
    model_reset();
    last_stb = -1;
    @(negedge clk);
    reset_n = 1'b1;
    rdata = 32'h0000_7FF8;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    txn(32'h0C80, 16'h0190);
    chk("cnt_after_rst", cnt0, 16'd1);
    txn(32'hE480, 16'hFC90);
    chk("neg_plan", avg0, 16'hFC90);
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
